// File: rtl/prl_rx_msg_ctrl.sv
// -----------------------------------------------------------------------------
// prl_rx_msg_ctrl
//
// Receive-side protocol-layer controller sitting behind the rx message parser.
// For every parsed message it decides whether a GoodCRC must be sent through
// the PHY, filters retransmitted messages by MessageID (one stored ID per SOP
// type 0-2), and presents accepted messages to the policy engine. Soft_Reset
// clears the stored ID of its SOP type; a missing GoodCRC completion is
// reported as a timeout.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   prl_rx_parser_message_req      1-cycle pulse, parsed message available
//   prl_rx_parser_sop_type/..._id  header fields captured on the pulse
//   prl_hard_reset                 level, clears all state (highest priority)
//   prl2phy_goodcrc_req/_sop_type/_message_id
//                                  GoodCRC transmit request to the PHY
//   phy2prl_goodcrc_done           pulse, GoodCRC transmission finished
//   prl_rx_goodcrc_received        pulse, a GoodCRC message was received
//   prl2pe_rx_message_valid/_type/_header_type/_sop_type
//                                  message presented to the policy engine
//   pe2prl_rx_message_ack          policy-engine acknowledge
//   prl_rx_goodcrc_timeout_err     pulse, GoodCRC completion timed out
//   prl_rx_overrun                 pulse, request dropped because busy
// -----------------------------------------------------------------------------
module prl_rx_msg_ctrl #(
   parameter int                 TMR_W           = 8,
   parameter logic [TMR_W-1:0]   GOODCRC_TIMEOUT = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       prl_rx_parser_message_req,
   input  logic [2:0] prl_rx_parser_sop_type,
   input  logic [1:0] prl_rx_parser_message_type,
   input  logic [4:0] prl_rx_parser_header_type,
   input  logic [2:0] prl_rx_parser_message_id,
   input  logic       prl_hard_reset,
   output logic       prl2phy_goodcrc_req,
   output logic [2:0] prl2phy_goodcrc_sop_type,
   output logic [2:0] prl2phy_goodcrc_message_id,
   input  logic       phy2prl_goodcrc_done,
   output logic       prl_rx_goodcrc_received,
   output logic       prl2pe_rx_message_valid,
   output logic [1:0] prl2pe_rx_message_type,
   output logic [4:0] prl2pe_rx_header_type,
   output logic [2:0] prl2pe_rx_sop_type,
   input  logic       pe2prl_rx_message_ack,
   output logic       prl_rx_goodcrc_timeout_err,
   output logic       prl_rx_overrun
);

   localparam logic [1:0]       MSG_CONTROL    = 2'd0;
   localparam logic [4:0]       HDR_GOODCRC    = 5'h01;
   localparam logic [4:0]       HDR_SOFT_RESET = 5'h0D;
   localparam logic [TMR_W-1:0] TMR_LAST       = GOODCRC_TIMEOUT - 1'b1;
   localparam logic [TMR_W-1:0] TMR_MAX        = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_GOODCRC,
      ST_DELIVER
   } state_t;

   state_t           state, next_state;

   logic [2:0]       cap_sop;
   logic [1:0]       cap_mtype;
   logic [4:0]       cap_htype;
   logic [2:0]       cap_id;

   logic [2:0]       id_valid;
   logic [2:0]       id_store [3];
   logic [TMR_W-1:0] tmr;

   logic             clear_all;
   logic             is_goodcrc;
   logic             is_soft_reset;
   logic             is_sop;
   logic [1:0]       sop_idx;
   logic             is_dup;

   // control strobes from the next-state logic
   logic             id_wr;
   logic             id_clr;
   logic             tmr_clr;
   logic             timeout_hit;
   logic             gcrc_rx;

   assign clear_all     = !rst_n || prl_hard_reset;
   assign is_goodcrc    = (cap_mtype == MSG_CONTROL) && (cap_htype == HDR_GOODCRC);
   assign is_soft_reset = (cap_mtype == MSG_CONTROL) && (cap_htype == HDR_SOFT_RESET);
   assign is_sop        = (cap_sop < 3'd3);
   // only meaningful while is_sop holds, so the index never reaches 3
   assign sop_idx       = cap_sop[1:0];
   assign is_dup        = id_valid[sop_idx] && (id_store[sop_idx] == cap_id);

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      next_state  = state;
      id_wr       = 1'b0;
      id_clr      = 1'b0;
      tmr_clr     = 1'b0;
      timeout_hit = 1'b0;
      gcrc_rx     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (prl_rx_parser_message_req) next_state = ST_CHECK;
         end
         ST_CHECK: begin
            if (is_goodcrc) begin
               gcrc_rx    = 1'b1;
               next_state = ST_IDLE;
            end else if (!is_sop) begin
               next_state = ST_DELIVER;
            end else begin
               // Soft_Reset drops the stored ID before the duplicate test
               id_clr     = is_soft_reset;
               tmr_clr    = 1'b1;
               next_state = ST_GOODCRC;
            end
         end
         ST_GOODCRC: begin
            // done takes precedence over an expiring timer in the same cycle
            if (phy2prl_goodcrc_done) begin
               if (is_dup) begin
                  next_state = ST_IDLE;
               end else begin
                  id_wr      = 1'b1;
                  next_state = ST_DELIVER;
               end
            end else if (tmr == TMR_LAST) begin
               timeout_hit = 1'b1;
               next_state  = ST_IDLE;
            end
         end
         ST_DELIVER: begin
            if (pe2prl_rx_message_ack) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (clear_all) begin
         state                      <= ST_IDLE;
         cap_sop                    <= '0;
         cap_mtype                  <= '0;
         cap_htype                  <= '0;
         cap_id                     <= '0;
         id_valid                   <= '0;
         tmr                        <= '0;
         prl_rx_goodcrc_timeout_err <= 1'b0;
         prl_rx_overrun             <= 1'b0;
      end else begin
         state <= next_state;

         if ((state == ST_IDLE) && prl_rx_parser_message_req) begin
            cap_sop   <= prl_rx_parser_sop_type;
            cap_mtype <= prl_rx_parser_message_type;
            cap_htype <= prl_rx_parser_header_type;
            cap_id    <= prl_rx_parser_message_id;
         end

         if (tmr_clr) begin
            tmr <= '0;
         end else if ((state == ST_GOODCRC) && (tmr != TMR_MAX)) begin
            tmr <= tmr + 1'b1;
         end

         if (id_clr) id_valid[sop_idx] <= 1'b0;
         if (id_wr)  id_valid[sop_idx] <= 1'b1;

         prl_rx_goodcrc_timeout_err <= timeout_hit;
         prl_rx_overrun             <= prl_rx_parser_message_req && (state != ST_IDLE);
      end
   end

   // NOTE: the stored ID values carry no reset; the valid bits gate every use
   // of them, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (!clear_all && id_wr) id_store[sop_idx] <= cap_id;
   end

   assign prl2phy_goodcrc_req        = (state == ST_GOODCRC);
   assign prl2phy_goodcrc_sop_type   = cap_sop;
   assign prl2phy_goodcrc_message_id = cap_id;
   assign prl_rx_goodcrc_received    = gcrc_rx;
   assign prl2pe_rx_message_valid    = (state == ST_DELIVER);
   assign prl2pe_rx_message_type     = cap_mtype;
   assign prl2pe_rx_header_type      = cap_htype;
   assign prl2pe_rx_sop_type         = cap_sop;

endmodule

// File: tb/tb_prl_rx_msg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prl_rx_msg_ctrl
//
// Transaction-level bench for prl_rx_msg_ctrl. A directed sequence walks the
// main scenarios, then random messages follow. Expected behaviour comes from a
// message-level model: a table of last accepted MessageID per SOP type and the
// accept/duplicate/timeout rules applied once per message.
// -----------------------------------------------------------------------------
module tb_prl_rx_msg_ctrl;

   localparam int TIMEOUT = 200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       msg_req;
   logic [2:0] msg_sop;
   logic [1:0] msg_mtype;
   logic [4:0] msg_htype;
   logic [2:0] msg_id;
   logic       hard_reset;
   logic       gcrc_req;
   logic [2:0] gcrc_sop;
   logic [2:0] gcrc_id;
   logic       gcrc_done;
   logic       gcrc_received;
   logic       pe_valid;
   logic [1:0] pe_mtype;
   logic [4:0] pe_htype;
   logic [2:0] pe_sop;
   logic       pe_ack;
   logic       timeout_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   // message-level reference state: last accepted ID per SOP type
   logic [2:0] mdl_id  [3];
   bit         mdl_vld [3];

   always #5 clk = ~clk;

   prl_rx_msg_ctrl #(.TMR_W(8), .GOODCRC_TIMEOUT(8'd200)) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .prl_rx_parser_message_req  (msg_req),
      .prl_rx_parser_sop_type     (msg_sop),
      .prl_rx_parser_message_type (msg_mtype),
      .prl_rx_parser_header_type  (msg_htype),
      .prl_rx_parser_message_id   (msg_id),
      .prl_hard_reset             (hard_reset),
      .prl2phy_goodcrc_req        (gcrc_req),
      .prl2phy_goodcrc_sop_type   (gcrc_sop),
      .prl2phy_goodcrc_message_id (gcrc_id),
      .phy2prl_goodcrc_done       (gcrc_done),
      .prl_rx_goodcrc_received    (gcrc_received),
      .prl2pe_rx_message_valid    (pe_valid),
      .prl2pe_rx_message_type     (pe_mtype),
      .prl2pe_rx_header_type      (pe_htype),
      .prl2pe_rx_sop_type         (pe_sop),
      .pe2prl_rx_message_ack      (pe_ack),
      .prl_rx_goodcrc_timeout_err (timeout_err),
      .prl_rx_overrun             (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".gcrc_req"}, gcrc_req, 0);
      check({tag, ".gcrc_sop"}, gcrc_sop, 0);
      check({tag, ".gcrc_id"}, gcrc_id, 0);
      check({tag, ".gcrc_rx"}, gcrc_received, 0);
      check({tag, ".valid"}, pe_valid, 0);
      check({tag, ".pe_fields"}, {pe_mtype, pe_htype, pe_sop}, 0);
      check({tag, ".tmo"}, timeout_err, 0);
      check({tag, ".ovr"}, overrun, 0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++) mdl_vld[i] = 1'b0;
   endtask

   // One complete message. done_dly: GOODCRC cycle index at which done is
   // driven (>= TIMEOUT means never). poke: send a second request mid-GOODCRC.
   task automatic run_msg(input logic [2:0] sop, input logic [1:0] mt, input logic [4:0] ht,
                          input logic [2:0] id, input int done_dly, input int ack_dly,
                          input bit poke);
      bit is_gc, is_sr, deliver;
      int last_k;
      is_gc   = (mt == 2'd0) && (ht == 5'h01);
      is_sr   = (mt == 2'd0) && (ht == 5'h0D);
      deliver = 1'b0;

      msg_req = 1'b1; msg_sop = sop; msg_mtype = mt; msg_htype = ht; msg_id = id;
      next_cycle();
      msg_req = 1'b0;
      @(negedge clk);
      check("check.gcrc_rx", gcrc_received, is_gc);
      check("check.gcrc_req", gcrc_req, 0);
      next_cycle();

      if (is_gc) begin
         @(negedge clk);
         check("gc.gcrc_req", gcrc_req, 0);
         check("gc.valid", pe_valid, 0);
         check("gc.gcrc_rx_once", gcrc_received, 0);
      end else if (sop >= 3'd3) begin
         deliver = 1'b1;
      end else begin
         if (is_sr) mdl_vld[sop] = 1'b0;
         last_k = (done_dly < TIMEOUT) ? done_dly : TIMEOUT - 1;
         for (int k = 0; k <= last_k; k++) begin
            gcrc_done = (k == done_dly);
            msg_req   = poke && (k == 1);
            if (msg_req) begin
               msg_sop = 3'($urandom_range(0, 7)); msg_id = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            check("gcrc.req", gcrc_req, 1);
            check("gcrc.fields", {gcrc_sop, gcrc_id}, {sop, id});
            check("gcrc.overrun", overrun, poke && (k == 2));
            check("gcrc.tmo", timeout_err, 0);
            next_cycle();
         end
         gcrc_done = 1'b0;
         msg_req   = 1'b0;
         @(negedge clk);
         check("post.gcrc_req", gcrc_req, 0);
         if (done_dly >= TIMEOUT) begin
            check("tmo.pulse", timeout_err, 1);
            check("tmo.valid", pe_valid, 0);
            next_cycle();
            @(negedge clk);
            check("tmo.pulse_end", timeout_err, 0);
         end else begin
            check("done.no_tmo", timeout_err, 0);
            if (mdl_vld[sop] && mdl_id[sop] == id) begin
               check("dup.valid", pe_valid, 0);
            end else begin
               mdl_vld[sop] = 1'b1;
               mdl_id[sop]  = id;
               deliver      = 1'b1;
            end
         end
      end

      if (deliver) begin
         for (int j = 0; j <= ack_dly; j++) begin
            @(negedge clk);
            check("dlv.valid", pe_valid, 1);
            check("dlv.fields", {pe_mtype, pe_htype, pe_sop}, {mt, ht, sop});
            check("dlv.gcrc_req", gcrc_req, 0);
            if (j == ack_dly) pe_ack = 1'b1;
            next_cycle();
         end
         pe_ack = 1'b0;
         @(negedge clk);
         check("ack.valid_drop", pe_valid, 0);
      end
      next_cycle();
   endtask

   // A message is cut off by prl_hard_reset a few cycles into GOODCRC.
   task automatic hard_reset_mid_goodcrc(input logic [2:0] sop, input logic [2:0] id);
      msg_req = 1'b1; msg_sop = sop; msg_mtype = 2'd1; msg_htype = 5'h02; msg_id = id;
      next_cycle();
      msg_req = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("hr.in_gcrc", gcrc_req, 1);
      hard_reset = 1'b1;
      gcrc_done  = 1'b1;
      next_cycle();
      hard_reset = 1'b0;
      gcrc_done  = 1'b0;
      clear_model();
      @(negedge clk);
      check_all_zero("hr");
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b0; msg_req = 1'b0; msg_sop = '0; msg_mtype = '0; msg_htype = '0;
      msg_id = '0; hard_reset = 1'b0; gcrc_done = 1'b0; pe_ack = 1'b0;
      for (int i = 0; i < 3; i++) mdl_id[i] = '0;
      clear_model();
      repeat (3) next_cycle();
      @(negedge clk);
      check_all_zero("rst");
      rst_n = 1'b1;
      next_cycle();

      // directed walk
      run_msg(3'd0, 2'd1, 5'h02, 3'd3, 5, 0, 1'b0);    // delivered
      run_msg(3'd0, 2'd1, 5'h02, 3'd3, 2, 0, 1'b0);    // duplicate
      run_msg(3'd0, 2'd1, 5'h02, 3'd4, 5, 2, 1'b0);    // new id
      run_msg(3'd1, 2'd1, 5'h04, 3'd3, 0, 0, 1'b0);    // sop1 stores 3
      run_msg(3'd1, 2'd0, 5'h0D, 3'd3, 3, 1, 1'b0);    // Soft_Reset, not dup
      run_msg(3'd2, 2'd1, 5'h02, 3'd5, 300, 0, 1'b0);  // timeout
      run_msg(3'd2, 2'd1, 5'h02, 3'd5, 1, 0, 1'b0);    // replay delivered
      run_msg(3'd2, 2'd1, 5'h02, 3'd6, 199, 0, 1'b0);  // done on last timer cycle
      run_msg(3'd0, 2'd0, 5'h01, 3'd2, 0, 0, 1'b0);    // GoodCRC received
      run_msg(3'd4, 2'd2, 5'h07, 3'd1, 0, 3, 1'b0);    // non-SOP
      run_msg(3'd0, 2'd1, 5'h02, 3'd1, 5, 0, 1'b1);    // overrun mid GOODCRC
      run_msg(3'd0, 2'd1, 5'h02, 3'd7, 1, 0, 1'b0);
      run_msg(3'd0, 2'd1, 5'h02, 3'd0, 1, 0, 1'b0);    // 7 then 0 not dup
      hard_reset_mid_goodcrc(3'd0, 3'd2);
      run_msg(3'd0, 2'd1, 5'h02, 3'd0, 2, 0, 1'b0);    // valid bits cleared
      run_msg(3'd0, 2'd1, 5'h02, 3'd3, 2, 0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [2:0] s, id;
         logic [1:0] mt;
         logic [4:0] ht;
         int         dd, sel;
         s   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            mt = 2'd0; ht = 5'h01;
         end else if (sel == 1) begin
            mt = 2'd0; ht = 5'h0D;
         end else begin
            mt = 2'($urandom_range(0, 2)); ht = 5'($urandom_range(0, 31));
         end
         id = (s < 3 && $urandom_range(0, 1) == 1) ? mdl_id[s] : 3'($urandom_range(0, 7));
         dd = ($urandom_range(0, 9) == 0) ? 250 : $urandom_range(0, 6);
         run_msg(s, mt, ht, id, dd, $urandom_range(0, 3),
                 (dd >= 3) && ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prl_rx_msg_ctrl.md
Name: prl_rx_msg_ctrl

Overview:
Receive-side protocol-layer controller placed after the rx message parser. It takes each parsed-message request and decides whether to schedule a GoodCRC transmission through the PHY, checks for a retransmitted (duplicate) MessageID per SOP type, and hands the message to the policy engine. It also handles Soft_Reset ID clearing and the GoodCRC response timeout.

Parameters:
TMR_W, 8, width of the GoodCRC response timer.
GOODCRC_TIMEOUT, 8'd200, number of clk cycles allowed for phy2prl_goodcrc_done after the GoodCRC request is raised.

Ports:
clk  input  1  system clock; all logic is on posedge.
rst_n  input  1  reset, synchronous and active-low.
prl_rx_parser_message_req  input  1  one-cycle pulse: a parsed message with a good CRC is available.
prl_rx_parser_sop_type  input  3  SOP type of the message; values 0-2 are SOP/SOP'/SOP''.
prl_rx_parser_message_type  input  2  message class: 0 control, 1 data, 2 extended.
prl_rx_parser_header_type  input  5  header message-type field.
prl_rx_parser_message_id  input  3  header MessageID.
prl_hard_reset  input  1  level signal: clear all state.
prl2phy_goodcrc_req  output  1  level request to the PHY to transmit a GoodCRC.
prl2phy_goodcrc_sop_type  output  3  SOP type for that GoodCRC.
prl2phy_goodcrc_message_id  output  3  MessageID to echo in that GoodCRC.
phy2prl_goodcrc_done  input  1  pulse: the GoodCRC transmission has completed.
prl_rx_goodcrc_received  output  1  pulse to the tx path: a GoodCRC message was received.
prl2pe_rx_message_valid  output  1  level: a message is being presented to the policy engine.
prl2pe_rx_message_type  output  2  captured message class.
prl2pe_rx_header_type  output  5  captured header type.
prl2pe_rx_sop_type  output  3  captured SOP type.
pe2prl_rx_message_ack  input  1  policy-engine acknowledge.
prl_rx_goodcrc_timeout_err  output  1  pulse: GoodCRC response timed out.
prl_rx_overrun  output  1  pulse: a message request arrived while the block was busy.

Behaviour:
- Reset: rst_n low at a clk edge, or prl_hard_reset high at a clk edge, gives the following on the next cycle:
  - state IDLE;
  - all outputs 0;
  - capture registers 0;
  - stored-ID valid bits for SOP types 0-2 cleared to 0;
  - timer cleared to 0.
  - prl_hard_reset has priority over every other event.
- Capture: in IDLE, a prl_rx_parser_message_req pulse latches sop_type, message_type, header_type and message_id. The state moves to CHECK on the next cycle.
- A message_req in any state other than IDLE is dropped. prl_rx_overrun pulses for 1 cycle. The ongoing transaction is not affected.
- CHECK lasts 1 cycle and decodes the captured message:
  - GoodCRC received (type 0, header 5'h01): pulse prl_rx_goodcrc_received, no ID update, no delivery. Next state is IDLE.
  - sop_type 3 or higher (non-SOP): no GoodCRC, no ID check. Next state is DELIVER.
  - Otherwise: next state is GOODCRC.
  - Soft_Reset (type 0, header 5'h0D) clears the stored-ID valid bit for its SOP type in CHECK. The message is therefore never treated as a duplicate.
- GOODCRC:
  - prl2phy_goodcrc_req is held at 1. Its sop_type and message_id outputs show the captured values and stay stable until the request drops.
  - The timer counts up from 0, one step per cycle.
  - With the standard 1-cycle capture, message_req at cycle N gives goodcrc_req high from cycle N+2.
  - If phy2prl_goodcrc_done occurs:
    - goodcrc_req drops on the next cycle;
    - if the stored ID is valid and equal to the captured ID, the message is a duplicate and the next state is IDLE with no delivery;
    - otherwise the stored ID is set to the captured ID, its valid bit is set, and the next state is DELIVER.
    - The duplicate test uses the stored ID value from before this update.
  - If the timer reaches GOODCRC_TIMEOUT-1 with no done:
    - prl_rx_goodcrc_timeout_err pulses for 1 cycle;
    - goodcrc_req drops;
    - the stored ID is not changed;
    - the next state is IDLE with no delivery.
  - If done and the timeout occur in the same cycle, done wins.
- DELIVER:
  - prl2pe_rx_message_valid is held at 1 with the captured fields.
  - When pe2prl_rx_message_ack is seen with valid high, valid drops on the next cycle and the state returns to IDLE.
  - An ack outside DELIVER is ignored.
- Stored IDs: one 3-bit ID plus one valid bit per SOP type 0-2. Comparison is an exact 3-bit match, so ID 7 followed by ID 0 is not a duplicate.
- Timer: TMR_W bits. It is cleared on entry to GOODCRC and saturates, never wrapping.

Test Plan:
- Data message, sop 0, id 3, done after 5 cycles -> goodcrc_req high for cycles N+2 to N+7, goodcrc_message_id = 3; valid rises next cycle; ack drops valid; stored ID for sop 0 becomes 3.
- Repeat the same message (sop 0, id 3) -> GoodCRC is sent with id 3; no prl2pe valid.
- Same sequence with id 4 -> delivered.
- Soft_Reset, sop 1, id 3, after sop 1 has stored id 3 -> GoodCRC is sent and the message is delivered (not a duplicate); stored ID for sop 1 becomes 3.
- No done for 200 cycles -> timeout_err pulses once; goodcrc_req drops; no delivery.
- Replaying the same id after that timeout -> delivered.
- GoodCRC control message received (header 0x01), sop 0 -> goodcrc_received pulses once; goodcrc_req stays 0; valid stays 0.
- Non-SOP message (sop 4) -> valid 2 cycles after the req with no GoodCRC.
- message_req while in GOODCRC -> overrun pulses once and the transaction completes normally.
- prl_hard_reset asserted mid-GOODCRC -> next cycle all outputs are 0 and all valid bits are clear.
- After that hard reset, sop 0 id 3 is delivered.
